axi4l_native_bridge: RTL and testbench

Synthesizable AXI4-lite slave. Sits directly downstream of picorv32_axi and converts its AXI4-lite master port into a single-outstanding native memory request: mem_valid / mem_ready / mem_addr / mem_wdata / mem_wstrb / mem_rdata. Lets native-interface SRAM and MMIO (console, test-status) replace the behavioural AXI memory model. A watchdog aborts hung native transactions and flags a sticky bus error.

---
 rtl/axi4l_bridge_pkg.sv | 19 +
 rtl/axi4l_hold_reg.sv | 33 +++
 rtl/axi4l_native_bridge.sv | 180 ++++++++++++++++++
 tb/tb_axi4l_native_bridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_bridge_pkg.sv
// Shared types and constants for the AXI4-lite to native memory bridge.
package axi4l_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RRESP,
    ST_BRESP
  } state_t;

  typedef enum logic {
    GNT_READ,
    GNT_WRITE
  } grant_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/axi4l_hold_reg.sv
// One-entry valid/ready holding register; ready comes straight from a flop.
module axi4l_hold_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] q
);

  // Ready is its own flop so it stays low during reset and rises one edge later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      q        <= '0;
    end else if (in_valid && in_ready) begin
      full     <= 1'b1;
      in_ready <= 1'b0;
      q        <= in_data;
    end else if (clr) begin
      full     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      in_ready <= !full;
    end
  end

endmodule

// File: rtl/axi4l_native_bridge.sv
// AXI4-lite slave converted to a single-outstanding native memory request,
// with a watchdog that aborts hung native transactions.
module axi4l_native_bridge
  import axi4l_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic        ar_full, aw_full, w_full;
  logic        ar_clr, aw_clr, w_clr;
  logic [32:0] ar_q;
  logic [31:0] aw_q;
  logic [35:0] w_q;

  axi4l_hold_reg #(.W(33)) u_ar (
    .clk(clk), .resetn(resetn), .in_valid(mem_axi_arvalid), .in_ready(mem_axi_arready),
    .in_data({mem_axi_arprot[2], mem_axi_araddr}), .clr(ar_clr), .full(ar_full), .q(ar_q)
  );

  axi4l_hold_reg #(.W(32)) u_aw (
    .clk(clk), .resetn(resetn), .in_valid(mem_axi_awvalid), .in_ready(mem_axi_awready),
    .in_data(mem_axi_awaddr), .clr(aw_clr), .full(aw_full), .q(aw_q)
  );

  axi4l_hold_reg #(.W(36)) u_w (
    .clk(clk), .resetn(resetn), .in_valid(mem_axi_wvalid), .in_ready(mem_axi_wready),
    .in_data({mem_axi_wstrb, mem_axi_wdata}), .clr(w_clr), .full(w_full), .q(w_q)
  );

  logic unused_bits;
  assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot[1:0], ar_q[1:0], aw_q[1:0]};

  state_t        state, state_d;
  grant_t        last_grant, last_grant_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          mem_valid_d, mem_instr_d, rvalid_d, bvalid_d, bus_error_d;
  logic [31:0]   mem_addr_d, mem_wdata_d, rdata_d;
  logic [3:0]    mem_wstrb_d;
  logic          wr_go;

  // A pending read loses a tie only when the previous grant was a read.
  assign wr_go = aw_full && w_full && (!ar_full || last_grant == GNT_READ);

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    mem_valid_d  = mem_valid;
    mem_instr_d  = mem_instr;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_wstrb_d  = mem_wstrb;
    rvalid_d     = mem_axi_rvalid;
    bvalid_d     = mem_axi_bvalid;
    rdata_d      = mem_axi_rdata;
    bus_error_d  = bus_error;
    ar_clr       = 1'b0;
    aw_clr       = 1'b0;
    w_clr        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_go) begin
          state_d      = ST_WR;
          last_grant_d = GNT_WRITE;
          cnt_d        = '0;
          mem_valid_d  = 1'b1;
          mem_instr_d  = 1'b0;
          mem_addr_d   = {aw_q[31:2], 2'b00};
          mem_wdata_d  = w_q[31:0];
          mem_wstrb_d  = w_q[35:32];
        end else if (ar_full) begin
          state_d      = ST_RD;
          last_grant_d = GNT_READ;
          cnt_d        = '0;
          mem_valid_d  = 1'b1;
          mem_instr_d  = ar_q[32];
          mem_addr_d   = {ar_q[31:2], 2'b00};
          mem_wdata_d  = '0;
          mem_wstrb_d  = '0;
        end
      end
      ST_RD, ST_WR: begin
        // A completion in the watchdog's final cycle takes priority over the abort.
        if (mem_ready || cnt == CNT_MAX) begin
          mem_valid_d = 1'b0;
          if (!mem_ready) bus_error_d = 1'b1;
          if (state == ST_RD) begin
            ar_clr   = 1'b1;
            rvalid_d = 1'b1;
            rdata_d  = mem_ready ? mem_rdata : ERR_RDATA;
            state_d  = ST_RRESP;
          end else begin
            aw_clr   = 1'b1;
            w_clr    = 1'b1;
            bvalid_d = 1'b1;
            state_d  = ST_BRESP;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_RRESP: begin
        if (mem_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_BRESP: begin
        if (mem_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      last_grant     <= GNT_WRITE;
      cnt            <= '0;
      mem_valid      <= 1'b0;
      mem_instr      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      mem_axi_rvalid <= 1'b0;
      mem_axi_bvalid <= 1'b0;
      mem_axi_rdata  <= '0;
      bus_error      <= 1'b0;
    end else begin
      state          <= state_d;
      last_grant     <= last_grant_d;
      cnt            <= cnt_d;
      mem_valid      <= mem_valid_d;
      mem_instr      <= mem_instr_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      mem_wstrb      <= mem_wstrb_d;
      mem_axi_rvalid <= rvalid_d;
      mem_axi_bvalid <= bvalid_d;
      mem_axi_rdata  <= rdata_d;
      bus_error      <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_axi4l_native_bridge.sv
// Randomized bench for axi4l_native_bridge against a transaction-level model.
module tb_axi4l_native_bridge;

  localparam int unsigned TIMEOUT = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        bus_error;

  axi4l_native_bridge #(.TIMEOUT(TIMEOUT), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: queues of accepted requests, one active native
  // request, and the response it is owed.
  typedef enum {M_IDLE, M_NATIVE, M_RESP} mphase_t;
  mphase_t     ph;
  logic [32:0] q_ar[$];
  logic [31:0] q_aw[$];
  logic [35:0] q_w[$];
  bit          cur_rd, tie_read_next, err_model;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_strb;
  logic        exp_instr;
  int unsigned edges_high;
  bit          hs_ar, hs_aw, hs_w, rdy_edge, resp_hs;
  logic [32:0] ar_pend;
  logic [31:0] aw_pend;
  logic [35:0] w_pend;
  logic [31:0] rdata_edge;

  task automatic model_reset();
    q_ar.delete(); q_aw.delete(); q_w.delete();
    ph = M_IDLE; tie_read_next = 1'b1; err_model = 1'b0;
    hs_ar = 0; hs_aw = 0; hs_w = 0; rdy_edge = 0; resp_hs = 0;
  endtask

  task automatic drive_idle();
    mem_axi_awvalid = 0; mem_axi_awaddr = '0; mem_axi_awprot = '0;
    mem_axi_wvalid = 0; mem_axi_wdata = '0; mem_axi_wstrb = '0;
    mem_axi_arvalid = 0; mem_axi_araddr = '0; mem_axi_arprot = '0;
    mem_axi_bready = 0; mem_axi_rready = 0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_axi_rvalid,
                mem_axi_bvalid, mem_axi_arready, mem_axi_awready, mem_axi_wready, bus_error}, '0);
  endtask

  // Called at each negedge: account for what the previous posedge did, then drive the next one.
  task automatic step(input int unsigned p_rdy, input int unsigned p_resp, input bit force_tie);
    bit rd_p, wr_p;
    logic [32:0] a;
    logic [31:0] aw;
    logic [35:0] w;
    case (ph)
      M_IDLE: begin
        rd_p = q_ar.size() != 0;
        wr_p = q_aw.size() != 0 && q_w.size() != 0;
        if (rd_p || wr_p) begin
          cur_rd = rd_p && (!wr_p || tie_read_next);
          tie_read_next = !cur_rd;
          if (cur_rd) begin
            a = q_ar[0];
            exp_addr = {a[31:2], 2'b00}; exp_strb = '0; exp_instr = a[32];
          end else begin
            aw = q_aw[0]; w = q_w[0];
            exp_addr = {aw[31:2], 2'b00}; exp_strb = w[35:32]; exp_wdata = w[31:0]; exp_instr = 0;
          end
          edges_high = 0;
          ph = M_NATIVE;
          check("grant_valid", mem_valid, 1);
        end else begin
          check("idle_quiet", mem_valid, 0);
        end
      end
      M_NATIVE: begin
        edges_high++;
        if (rdy_edge || edges_high == TIMEOUT) begin
          if (rdy_edge) exp_rdata = rdata_edge;
          else begin exp_rdata = ERR; err_model = 1'b1; end
          if (cur_rd) void'(q_ar.pop_front());
          else begin void'(q_aw.pop_front()); void'(q_w.pop_front()); end
          ph = M_RESP;
          check("done_drop", mem_valid, 0);
        end else begin
          check("hold_valid", mem_valid, 1);
        end
      end
      M_RESP: if (resp_hs) ph = M_IDLE;
      default: ph = M_IDLE;
    endcase

    if (ph == M_NATIVE) begin
      check("req_addr", mem_addr, exp_addr);
      check("req_strb", mem_wstrb, exp_strb);
      check("req_instr", mem_instr, exp_instr);
      if (!cur_rd) check("req_wdata", mem_wdata, exp_wdata);
    end
    if (ph == M_RESP) begin
      check("rvalid", mem_axi_rvalid, cur_rd);
      check("bvalid", mem_axi_bvalid, !cur_rd);
      if (cur_rd) check("rdata", mem_axi_rdata, exp_rdata);
    end else begin
      check("no_resp", {mem_axi_rvalid, mem_axi_bvalid}, 0);
    end
    check("bus_error", bus_error, err_model);

    if (hs_ar) q_ar.push_back(ar_pend);
    if (hs_aw) q_aw.push_back(aw_pend);
    if (hs_w)  q_w.push_back(w_pend);
    check("arready", mem_axi_arready, q_ar.size() == 0);
    check("awready", mem_axi_awready, q_aw.size() == 0);
    check("wready", mem_axi_wready, q_w.size() == 0);

    if (hs_ar) mem_axi_arvalid = 0;
    if (hs_aw) mem_axi_awvalid = 0;
    if (hs_w)  mem_axi_wvalid = 0;
    if (!mem_axi_arvalid && (force_tie || $urandom_range(0, 99) < 30)) begin
      mem_axi_arvalid = 1; mem_axi_araddr = $urandom; mem_axi_arprot = 3'($urandom);
    end
    if (!mem_axi_awvalid && (force_tie || $urandom_range(0, 99) < 30)) begin
      mem_axi_awvalid = 1; mem_axi_awaddr = $urandom; mem_axi_awprot = 3'($urandom);
    end
    if (!mem_axi_wvalid && (force_tie || $urandom_range(0, 99) < 30)) begin
      mem_axi_wvalid = 1; mem_axi_wdata = $urandom; mem_axi_wstrb = 4'($urandom_range(1, 15));
    end
    mem_axi_rready = $urandom_range(0, 99) < p_resp;
    mem_axi_bready = $urandom_range(0, 99) < p_resp;
    mem_ready = $urandom_range(0, 99) < p_rdy;
    mem_rdata = $urandom;

    hs_ar = mem_axi_arvalid && mem_axi_arready;
    hs_aw = mem_axi_awvalid && mem_axi_awready;
    hs_w  = mem_axi_wvalid && mem_axi_wready;
    ar_pend = {mem_axi_arprot[2], mem_axi_araddr};
    aw_pend = mem_axi_awaddr;
    w_pend  = {mem_axi_wstrb, mem_axi_wdata};
    resp_hs = (mem_axi_rvalid && mem_axi_rready) || (mem_axi_bvalid && mem_axi_bready);
    rdy_edge = mem_ready;
    rdata_edge = mem_rdata;
  endtask

  task automatic run(input int unsigned cycles, input int unsigned p_rdy, input int unsigned p_resp);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      step(p_rdy, p_resp, 1'b0);
    end
  endtask

  initial begin
    bit found;
    resetn = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    resetn = 1'b1;

    @(negedge clk);
    step(50, 70, 1'b1);
    run(1500, 50, 70);
    run(1500, 10, 30);
    run(500, 100, 100);

    // Reset asynchronously while a native write is in flight.
    found = 1'b0;
    for (int unsigned i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      step(0, 60, 1'b0);
      if (ph == M_NATIVE && !cur_rd) found = 1'b1;
    end
    check("find_wr", found, 1);
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    drive_idle();
    model_reset();
    @(negedge clk);
    check_all_zero("reset_hold");
    resetn = 1'b1;

    @(negedge clk);
    step(60, 60, 1'b1);
    run(800, 60, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
